pipelined_addsub_flags: RTL

- Parametrised successor of the team's combinational N-bit adder.
- Performs ADD/SUB/ADC/SBC on N-bit operands through a STAGES-deep carry-split pipeline with valid/ready handshakes on both sides.
- Produces a 4-bit NZCV-style flag word with every result, plus a sticky overflow flag.
- Sits between the operand-select logic and the result/flag register stage of the lab datapath.

---
 rtl/addsub_pkg.sv | 17 +
 rtl/addsub_chunk_stage.sv | 51 +++++
 rtl/pipelined_addsub_flags.sv | 128 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined add/sub unit.
// The flag word is laid out as {N, V, C, Z}.
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_ADC = 2'b10,
    OP_SBC = 2'b11
  } op_t;

  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 3;

endpackage

// File: rtl/addsub_chunk_stage.sv
// One pipeline slice: adds chunk Idx of the (pre-conditioned) operands and registers
// the carry, the partially built result and the operands for the following slices.
module addsub_chunk_stage #(
  parameter int unsigned N   = 8,
  parameter int unsigned W   = 4,
  parameter int unsigned Idx = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           valid_in,
  input  logic           cin,
  input  logic [2*N-1:0] ops_in,
  input  logic [N-1:0]   res_in,
  output logic           valid_out,
  output logic           carry_out,
  output logic [2*N-1:0] ops_out,
  output logic [N-1:0]   res_out
);

  logic [W-1:0] a_chunk;
  logic [W-1:0] b_chunk;
  logic [W:0]   sum;
  logic [N-1:0] res_d;

  // ops_in packs {a, b'} where b' is already inverted for subtraction.
  always_comb begin
    a_chunk            = ops_in[N + Idx*W +: W];
    b_chunk            = ops_in[Idx*W +: W];
    sum                = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, cin};
    res_d              = res_in;
    res_d[Idx*W +: W]  = sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out <= 1'b0;
      carry_out <= 1'b0;
      ops_out   <= '0;
      res_out   <= '0;
    end else if (en) begin
      valid_out <= valid_in;
      if (valid_in) begin
        carry_out <= sum[W];
        ops_out   <= ops_in;
        res_out   <= res_d;
      end
    end
  end

endmodule

// File: rtl/pipelined_addsub_flags.sv
// Carry-split pipelined ADD/SUB/ADC/SBC with NZCV flags, valid/ready handshakes
// and a sticky overflow flag. One chunk slice per stage, then a result/flag register.
module pipelined_addsub_flags
  import addsub_pkg::*;
#(
  parameter int unsigned N      = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         ovf_sticky,
  input  logic         clr_sticky
);

  localparam int unsigned W = N / STAGES;

  logic         en;
  op_t          op_e;
  logic [N-1:0] b_eff;
  logic         cin0;

  logic           valid_s [STAGES+1];
  logic           carry_s [STAGES+1];
  logic [2*N-1:0] ops_s   [STAGES+1];
  logic [N-1:0]   res_s   [STAGES+1];

  logic         out_valid_q;
  logic [N-1:0] result_q;
  logic [3:0]   flags_d, flags_q;
  logic         sticky_q;
  logic [N-1:0] res_f;
  logic         a_msb, b_msb;

  // A single global enable keeps every stage in lockstep under backpressure.
  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;

  always_comb begin
    op_e  = op_t'(op);
    b_eff = b;
    cin0  = 1'b0;
    unique case (op_e)
      OP_ADD: begin b_eff = b;  cin0 = 1'b0; end
      OP_SUB: begin b_eff = ~b; cin0 = 1'b1; end
      OP_ADC: begin b_eff = b;  cin0 = cin;  end
      OP_SBC: begin b_eff = ~b; cin0 = cin;  end
      default: ;
    endcase
  end

  assign valid_s[0] = in_valid;
  assign carry_s[0] = cin0;
  assign ops_s[0]   = {a, b_eff};
  assign res_s[0]   = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    addsub_chunk_stage #(
      .N   (N),
      .W   (W),
      .Idx (k)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .valid_in  (valid_s[k]),
      .cin       (carry_s[k]),
      .ops_in    (ops_s[k]),
      .res_in    (res_s[k]),
      .valid_out (valid_s[k+1]),
      .carry_out (carry_s[k+1]),
      .ops_out   (ops_s[k+1]),
      .res_out   (res_s[k+1])
    );
  end

  // Flags come from the fully assembled result and the conditioned operand MSBs.
  always_comb begin
    res_f           = res_s[STAGES];
    a_msb           = ops_s[STAGES][2*N-1];
    b_msb           = ops_s[STAGES][N-1];
    flags_d         = '0;
    flags_d[FLAG_N] = res_f[N-1];
    flags_d[FLAG_V] = (a_msb == b_msb) && (res_f[N-1] != a_msb);
    flags_d[FLAG_C] = carry_s[STAGES];
    flags_d[FLAG_Z] = (res_f == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (en) begin
      out_valid_q <= valid_s[STAGES];
      if (valid_s[STAGES]) begin
        result_q <= res_f;
        flags_q  <= flags_d;
      end
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 1'b0;
    end else if (out_valid_q && out_ready && flags_q[FLAG_V]) begin
      sticky_q <= 1'b1;
    end else if (clr_sticky) begin
      sticky_q <= 1'b0;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flags      = flags_q;
  assign ovf_sticky = sticky_q;

endmodule
